// File: rtl/fetch_pkg.sv
// Shared fetch types: state encoding, buffer entry layout and the address range check.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  // True when no address bit at or above aw is set (target lies inside memory).
  function automatic logic in_range(input logic [XLEN-1:0] addr, input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction memory port, redirect input and decode-side handshake.
interface fetch_if #(parameter int W = 32);
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_instruction;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_instruction;
  logic [W-1:0] out_pc;
  logic         fault;
  logic [W-1:0] fault_addr;

  modport master (
    output imem_addr, out_valid, out_instruction, out_pc, fault, fault_addr,
    input  imem_instruction, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instruction, out_pc, fault, fault_addr,
    output imem_instruction, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO kept as a shift pair: slot0 is always the head, so the head
// registers keep their last contents when the buffer drains or is flushed.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);
  fetch_entry_t slot0, slot1;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign head       = slot0;
  assign head_valid = (count != 2'd0);

  // Slot and occupancy update; flush only clears the count, data is left in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (push && do_pop) begin
      if (count == 2'd1) begin
        slot0 <= din;
      end else begin
        slot0 <= slot1;
        slot1 <= din;
      end
    end else if (push) begin
      if (count == 2'd0) slot0 <= din;
      else               slot1 <= din;
      count <= count + 2'd1;
    end else if (do_pop) begin
      if (count == 2'd2) slot0 <= slot1;
      count <= count - 2'd1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: PC sequencing, redirect handling, sticky fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   ADDR_WIDTH        = 8,
  parameter int                   INSTRUCTION_WIDTH = XLEN,
  parameter logic [XLEN-1:0]      RESET_PC          = '0
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);
  fetch_state_t                 state;
  logic [INSTRUCTION_WIDTH-1:0] pc;
  logic [INSTRUCTION_WIDTH-1:0] fault_addr;
  logic [1:0]                   count;
  logic                         head_valid;
  fetch_entry_t                 head, din;
  logic pop, room, attempt, push, redirect_bad;

  assign pop          = head_valid && bus.out_ready;
  assign room         = (count != 2'd2) || pop;
  // A fetch attempt only turns into a push if pc is still inside memory.
  assign attempt      = (state == RUN) && !bus.redirect_valid && room;
  assign push         = attempt && in_range(pc, ADDR_WIDTH);
  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) || !in_range(bus.redirect_pc, ADDR_WIDTH);
  assign din          = '{pc: pc, instruction: bus.imem_instruction};

  assign bus.imem_addr       = pc;
  assign bus.out_valid       = head_valid;
  assign bus.out_pc          = head.pc;
  assign bus.out_instruction = head.instruction;
  assign bus.fault           = (state == FAULT);
  assign bus.fault_addr      = fault_addr;

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .din        (din),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  // PC / state / fault-address update; redirect outranks sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      fault_addr <= '0;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
      if (redirect_bad) begin
        state      <= FAULT;
        fault_addr <= bus.redirect_pc;
      end else begin
        state      <= RUN;
        fault_addr <= '0;
      end
    end else if (attempt) begin
      if (push) begin
        pc <= pc + INSTRUCTION_WIDTH'(INSTR_BYTES);
      end else begin
        state      <= FAULT;
        fault_addr <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, faults, async reset.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_if #(.W(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(8), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: word i holds 0x13 + i.
  assign bus.imem_instruction = 32'h13 + (bus.imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #1;
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_fault", {31'b0, bus.fault}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_instr", bus.out_instruction, 32'h0);
    check("rst_faddr", bus.fault_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Streaming with ready held high: no bubbles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stream_pc", bus.out_pc, 32'(4 * i));
      check("stream_instr", bus.out_instruction, 32'h13 + 32'(i));
    end

    // Backpressure from restart: buffer fills, pc holds at 0x8.
    rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_addr", bus.imem_addr, 32'h8);
    check("bp_pc", bus.out_pc, 32'h0);
    check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("bp_drain_pc", bus.out_pc, 32'(4 * i));
      check("bp_drain_instr", bus.out_instruction, 32'h13 + 32'(i));
    end

    // Redirect with two entries buffered.
    bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.out_ready = 1'b1;
    redirect(32'h40);
    check("redir_bubble", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("redir_valid", {31'b0, bus.out_valid}, 32'd1);
    check("redir_pc0", bus.out_pc, 32'h40);
    check("redir_instr0", bus.out_instruction, 32'h23);
    @(negedge clk);
    check("redir_pc1", bus.out_pc, 32'h44);

    // Misaligned redirect faults; out-of-range redirect updates fault_addr.
    redirect(32'h42);
    check("mis_fault", {31'b0, bus.fault}, 32'd1);
    check("mis_faddr", bus.fault_addr, 32'h42);
    repeat (3) @(negedge clk);
    check("mis_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mis_fault_hold", {31'b0, bus.fault}, 32'd1);
    redirect(32'h104);
    check("oor_faddr", bus.fault_addr, 32'h104);
    redirect(32'h10);
    check("clr_fault", {31'b0, bus.fault}, 32'd0);
    check("clr_faddr", bus.fault_addr, 32'h0);
    @(negedge clk);
    check("clr_pc", bus.out_pc, 32'h10);
    check("clr_valid", {31'b0, bus.out_valid}, 32'd1);

    // Sequential run off the end of memory.
    redirect(32'hF0);
    check("end_bubble", {31'b0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("end_pc", bus.out_pc, 32'hF0 + 32'(4 * k));
      check("end_nofault", {31'b0, bus.fault}, 32'd0);
    end
    @(negedge clk);
    check("end_fault", {31'b0, bus.fault}, 32'd1);
    check("end_faddr", bus.fault_addr, 32'h100);
    check("end_valid", {31'b0, bus.out_valid}, 32'd0);

    // Async reset while faulted clears the fault immediately.
    #2 rst = 1'b1;
    #1;
    check("arst_fault", {31'b0, bus.fault}, 32'd0);
    check("arst_faddr", bus.fault_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("arst2_valid_pre", {31'b0, bus.out_valid}, 32'd1);
    check("arst2_pc_pre", bus.out_pc, 32'h4);
    // Async reset mid-stream, with a redirect pending that must be lost.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    #2 rst = 1'b1;
    #1;
    check("arst2_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst2_pc", bus.out_pc, 32'h0);
    check("arst2_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("restart_valid", {31'b0, bus.out_valid}, 32'd1);
    check("restart_pc", bus.out_pc, 32'h0);
    check("restart_instr", bus.out_instruction, 32'h13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller that sequences the combinational instruction memory. Holds the program counter and drives the memory read address. Captures each returned word with its PC into a 2-entry buffer. Presents words to decode over a valid/ready handshake. Handles control-flow redirects and flags misaligned or out-of-range fetch targets as a sticky fault.

## Interface
- ADDR_WIDTH, 8, byte-address bits covered by instruction memory (memory holds 2^(ADDR_WIDTH-2) words)
- INSTRUCTION_WIDTH, 32, instruction and address width
- RESET_PC, 0, PC loaded on reset; must be word-aligned and in range

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  INSTRUCTION_WIDTH  byte read address to instruction memory; always equals pc
- imem_instruction  in  INSTRUCTION_WIDTH  word returned combinationally for imem_addr
- redirect_valid  in  1  load new PC (branch/jump taken); flushes buffer
- redirect_pc  in  INSTRUCTION_WIDTH  redirect target byte address
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head
- out_instruction  out  INSTRUCTION_WIDTH  head instruction
- out_pc  out  INSTRUCTION_WIDTH  head PC
- fault  out  1  sticky fetch fault
- fault_addr  out  INSTRUCTION_WIDTH  offending target address

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Reset values: pc=RESET_PC, buffer count=0, out_valid=0, out_instruction=0, out_pc=0, fault=0, fault_addr=0.
- pop = out_valid & out_ready.
- push = RUN & !redirect_valid & (count<2 | pop).
- On push: write {pc, imem_instruction} at buffer tail; pc <= pc+4, modulo 2^INSTRUCTION_WIDTH.
- Push and pop in the same cycle: count unchanged, order preserved. Head is always the oldest entry.
- Redirect: redirect_valid has priority over push and pop. Buffer is flushed (count=0, out_valid=0 next cycle). A pop in that same cycle is not considered consumed.
  - Aligned, in-range target: pc <= redirect_pc, state RUN.
  - Target with bits[1:0]≠0, or any bit ≥ ADDR_WIDTH set: state <= FAULT, fault <= 1, fault_addr <= redirect_pc, pc <= redirect_pc.
- Sequential fetch: if pc+4 would leave range (bit ADDR_WIDTH set), the push of the last in-range word still occurs. On the next fetch attempt, state goes to FAULT with fault_addr = pc, and no push occurs.
- FAULT state:
  - No pushes occur.
  - Entries already in the buffer still drain via pop.
  - fault stays high.
  - Only a valid in-range redirect returns to RUN and clears fault and fault_addr. A further bad redirect updates fault_addr.
- out_instruction and out_pc come from registers (buffer head). They hold their last value when out_valid=0.
- out_valid=0 ⇒ out_ready is ignored.

## Timing
- Fetch latency: a word is visible at out_* one cycle after the edge at which pc addressed it.
  - After reset release: first edge pushes RESET_PC; out_valid=1 after that edge.
- Throughput: one instruction per cycle while out_ready is held high.
- Redirect penalty: redirect sampled at edge E gives out_valid=0 after E. The target is pushed at E+1, so out_valid=1 with out_pc=target after E+1.
- Backpressure: with out_ready=0, the buffer fills in 2 cycles. pc then holds and imem_addr is stable.
- Asynchronous rst mid-operation: all outputs go to reset values immediately; any in-flight redirect is lost.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum {RUN, FAULT}
  - INSTR_BYTES = 4
  - fetch_entry_t struct {pc, instruction}
  - in_range(addr) function shared with any future data-memory checker
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and head outputs. fetch_unit holds pc, the state machine and fault logic.

## Test plan
- Reset release, RESET_PC=0, memory words 0..7 = 0x00000013+i, out_ready=1 → out_pc 0,4,8,… on consecutive cycles with matching words, no bubbles.
- out_ready=0 for 5 cycles after start → count saturates at 2, imem_addr holds at 0x8, out_pc stays 0. Releasing ready then yields 0,4,8 without loss or duplication.
- Redirect to 0x40 while buffer holds 2 entries and out_ready=1 → one bubble cycle, then out_pc=0x40, 0x44. The pre-redirect entries never appear.
- Redirect to 0x42 → fault=1, fault_addr=0x42, out_valid=0 indefinitely. Then redirect to 0x10 → fault=0, out_pc=0x10 one cycle later.
- Sequential run to last word 0xFC (ADDR_WIDTH=8) → 0xFC is delivered, then fault=1 with fault_addr=0x100.
- Assert rst asynchronously mid-stream with out_valid=1 → out_valid and fault drop immediately. After release, fetch restarts at RESET_PC.
